// File: rtl/spi_frame_tx.sv
// SPI mode-0 master transmitter for fixed-length frames.
// One accepted word becomes one chip-select window: lead-in, FRAME_BITS SCK
// periods shifted MSB first, trail-out, then a CS-high gap before the next word.
// All SPI pins and handshake outputs are registered.

module spi_frame_tx #(
  parameter int FRAME_BITS = 24,
  parameter int CLK_DIV    = 4,
  parameter int CS_LEAD    = 4,
  parameter int CS_TRAIL   = 4,
  parameter int GAP        = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  spi_clock,
  output logic                  spi_data,
  output logic                  spi_cs,
  output logic                  busy,
  output logic                  done
);

  // Counter widths; single-cycle phases still get a 1-bit counter so the
  // compare against the last value stays well formed.
  localparam int HALF_W  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int LEAD_W  = (CS_LEAD  > 1) ? $clog2(CS_LEAD)  : 1;
  localparam int TRAIL_W = (CS_TRAIL > 1) ? $clog2(CS_TRAIL) : 1;
  localparam int GAP_W   = (GAP      > 1) ? $clog2(GAP)      : 1;

  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS);
  localparam logic [LEAD_W-1:0]  LEAD_LAST  = LEAD_W'(CS_LEAD - 1);
  localparam logic [TRAIL_W-1:0] TRAIL_LAST = TRAIL_W'(CS_TRAIL - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [HALF_W-1:0]     half_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [LEAD_W-1:0]     lead_cnt;
  logic [TRAIL_W-1:0]    trail_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  // Frame sequencer: every output is a register updated alongside the state,
  // so spi_data only ever moves together with an SCK fall or a CS edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      lead_cnt  <= '0;
      trail_cnt <= '0;
      gap_cnt   <= '0;
      tx_ready  <= 1'b1;
      spi_clock <= 1'b0;
      spi_data  <= 1'b0;
      spi_cs    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (tx_valid && tx_ready) begin
            // MSB goes straight onto the pin; the register keeps the rest
            // left-aligned so the next bit is always shift_reg[MSB].
            spi_data  <= tx_data[FRAME_BITS-1];
            shift_reg <= {tx_data[FRAME_BITS-2:0], 1'b0};
            spi_cs    <= 1'b0;
            busy      <= 1'b1;
            tx_ready  <= 1'b0;
            lead_cnt  <= '0;
            state     <= ST_LEAD;
          end
        end

        ST_LEAD: begin
          if (lead_cnt == LEAD_LAST) begin
            lead_cnt <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end else begin
            lead_cnt <= lead_cnt + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!spi_clock) begin
              spi_clock <= 1'b1;
              bit_cnt   <= bit_cnt + 1'b1;
            end else begin
              spi_clock <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                // Last bit stays on the pin through the trail-out.
                trail_cnt <= '0;
                state     <= ST_TRAIL;
              end else begin
                spi_data  <= shift_reg[FRAME_BITS-1];
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        ST_TRAIL: begin
          if (trail_cnt == TRAIL_LAST) begin
            spi_cs   <= 1'b1;
            spi_data <= 1'b0;
            done     <= 1'b1;
            gap_cnt  <= '0;
            state    <= ST_GAP;
          end else begin
            trail_cnt <= trail_cnt + 1'b1;
          end
        end

        ST_GAP: begin
          done <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Self-checking bench for spi_frame_tx.
// Two instances share clock and reset: dut_a at CLK_DIV=4 and dut_b at CLK_DIV=5.
// A frame-offset model predicts every output on every cycle, a mode-0 slave
// model reassembles words on SCK rises, and literal checks pin the timing.

module tb_spi_frame_tx;

  localparam int N     = 24;
  localparam int LEAD  = 4;
  localparam int TRAIL = 4;
  localparam int GAPC  = 8;

  localparam logic [5:0] IDLE_OUTS = 6'b100100;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n;
  logic [N-1:0] tx_data_a, tx_data_b;
  logic         tx_valid_a, tx_valid_b;
  logic         rdy_a, sck_a, sdo_a, cs_a, busy_a, done_a;
  logic         rdy_b, sck_b, sdo_b, cs_b, busy_b, done_b;

  spi_frame_tx #(.FRAME_BITS(N), .CLK_DIV(4), .CS_LEAD(LEAD), .CS_TRAIL(TRAIL), .GAP(GAPC)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(rdy_a), .spi_clock(sck_a), .spi_data(sdo_a), .spi_cs(cs_a),
    .busy(busy_a), .done(done_a)
  );

  spi_frame_tx #(.FRAME_BITS(N), .CLK_DIV(5), .CS_LEAD(LEAD), .CS_TRAIL(TRAIL), .GAP(GAPC)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(rdy_b), .spi_clock(sck_b), .spi_data(sdo_b), .spi_cs(cs_b),
    .busy(busy_b), .done(done_b)
  );

  // Free-running 100 MHz-style clock.
  always #5 sys_clk = ~sys_clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Model state: accept cycle and latched word per instance.
  bit           act [2];
  int           acc [2];
  logic [N-1:0] mword [2];
  int           accepts [2];
  logic [N-1:0] exp_q0 [$];
  logic [N-1:0] exp_q1 [$];

  // Slave model and measurement state.
  bit           prev_cs [2];
  bit           prev_sck [2];
  bit           prev_data [2];
  int           low_len [2];
  int           high_len [2];
  int           rises [2];
  int           first_rise [2];
  int           last_rise [2];
  int           period [2];
  int           gap_rec [2];
  int           fr_rises [2];
  int           fr_low [2];
  int           fr_first [2];
  int           done_cnt [2];
  int           rdy_viol [2];
  int           cap_cnt [2];
  logic [N-1:0] sreg [2];
  logic [N-1:0] last_cap [2];
  logic [N-1:0] prev_cap [2];
  logic [15:0]  freq_div [2];
  logic [15:0]  lfsr [2];

  function automatic int hdiv(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int low_of(input int d);
    return LEAD + 2 * hdiv(d) * N + TRAIL;
  endfunction

  function automatic logic [5:0] outs(input int d);
    if (d == 0) return {rdy_a, sck_a, sdo_a, cs_a, busy_a, done_a};
    return {rdy_b, sck_b, sdo_b, cs_b, busy_b, done_b};
  endfunction

  function automatic bit model_busy(input int d);
    return act[d] && ((cyc - acc[d]) < low_of(d) + GAPC);
  endfunction

  // Outputs as a function of how many cycles have passed since the accept edge.
  function automatic logic [5:0] model_out(input int d);
    int   k, h, lo, j, idx;
    logic s, dt;
    if (!sys_rst_n || !act[d]) return IDLE_OUTS;
    h  = hdiv(d);
    lo = low_of(d);
    k  = cyc - acc[d];
    if (k >= lo + GAPC) return IDLE_OUTS;
    s  = 1'b0;
    dt = 1'b0;
    if (k < LEAD) begin
      dt = mword[d][N-1];
    end else if (k < LEAD + 2 * h * N) begin
      j   = k - LEAD;
      s   = ((j / h) % 2) == 1;
      idx = j / (2 * h);
      if (idx > N - 1) idx = N - 1;
      dt  = mword[d][N-1-idx];
    end else if (k < lo) begin
      dt = mword[d][0];
    end
    return {1'b0, s, dt, (k >= lo), 1'b1, (k == lo)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic capture(input int d, input logic [N-1:0] w);
    cap_cnt[d]++;
    prev_cap[d] = last_cap[d];
    last_cap[d] = w;
    if (w[N-1]) lfsr[d] = w[15:0];
    else        freq_div[d] = w[15:0];
    if (d == 0) begin
      checkOutput("capture_pending_a", 32'(exp_q0.size() != 0), 32'd1);
      if (exp_q0.size() != 0) checkOutput("capture_a", 32'(w), 32'(exp_q0.pop_front()));
    end else begin
      checkOutput("capture_pending_b", 32'(exp_q1.size() != 0), 32'd1);
      if (exp_q1.size() != 0) checkOutput("capture_b", 32'(w), 32'(exp_q1.pop_front()));
    end
  endtask

  task automatic slave_update(input int d, input logic [5:0] o);
    bit rdy, sck, dat, cs, dn;
    rdy = o[5]; sck = o[4]; dat = o[3]; cs = o[2]; dn = o[0];
    if (dn) done_cnt[d]++;
    if (!cs) begin
      if (prev_cs[d]) begin
        gap_rec[d]    = high_len[d];
        low_len[d]    = 0;
        rises[d]      = 0;
        first_rise[d] = -1;
        last_rise[d]  = -1;
      end
      low_len[d]++;
      if (rdy) rdy_viol[d]++;
      if (sck && !prev_sck[d]) begin
        checkOutput(d == 0 ? "rise_hold_a" : "rise_hold_b", 32'(dat), 32'(prev_data[d]));
        sreg[d] = {sreg[d][N-2:0], dat};
        if (first_rise[d] < 0) first_rise[d] = low_len[d] - 1;
        if (last_rise[d] >= 0) period[d] = cyc - last_rise[d];
        last_rise[d] = cyc;
        rises[d]++;
      end
    end else begin
      if (!prev_cs[d]) begin
        fr_rises[d] = rises[d];
        fr_low[d]   = low_len[d];
        fr_first[d] = first_rise[d];
        high_len[d] = 0;
        if (rises[d] == N) capture(d, sreg[d]);
      end
      high_len[d]++;
    end
    prev_cs[d]   = cs;
    prev_sck[d]  = sck;
    prev_data[d] = dat;
  endtask

  task automatic compare_cycle();
    logic [5:0] o, e;
    for (int d = 0; d < 2; d++) begin
      o = outs(d);
      e = model_out(d);
      checkOutput(d == 0 ? "outs_a" : "outs_b", 32'(o), 32'(e));
      slave_update(d, o);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic         v;
      logic [N-1:0] w;
      bit           rdy;
      v = (d == 0) ? tx_valid_a : tx_valid_b;
      w = (d == 0) ? tx_data_a : tx_data_b;
      if (!sys_rst_n) begin
        act[d] = 1'b0;
      end else begin
        if (act[d] && (cyc - acc[d]) == low_of(d)) begin
          if (d == 0) exp_q0.push_back(mword[d]);
          else        exp_q1.push_back(mword[d]);
        end
        rdy = !act[d] || ((cyc - 1 - acc[d]) >= low_of(d) + GAPC);
        if (rdy && v === 1'b1) begin
          act[d]   = 1'b1;
          acc[d]   = cyc;
          mword[d] = w;
          accepts[d]++;
        end
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising
  // edge, then hand control back 2 time units later for input driving.
  task automatic tick();
    @(negedge sys_clk);
    compare_cycle();
    @(posedge sys_clk);
    cyc++;
    model_edge();
    #2;
  endtask

  task automatic applyStimulus(input int d, input logic [N-1:0] w, input bit keep);
    int a0;
    a0 = accepts[d];
    if (d == 0) begin tx_valid_a = 1'b1; tx_data_a = w; end
    else        begin tx_valid_b = 1'b1; tx_data_b = w; end
    for (int i = 0; i < 4000 && accepts[d] == a0; i++) tick();
    checkOutput(d == 0 ? "accept_a" : "accept_b", 32'(accepts[d] != a0), 32'd1);
    if (!keep) begin
      if (d == 0) begin tx_valid_a = 1'b0; tx_data_a = N'($urandom); end
      else        begin tx_valid_b = 1'b0; tx_data_b = N'($urandom); end
    end
  endtask

  task automatic waitIdle(input int d);
    for (int i = 0; i < 4000 && model_busy(d); i++) tick();
    checkOutput(d == 0 ? "idle_a" : "idle_b", 32'(model_busy(d)), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int           c0, dc0;
    int           idle;
    logic [N-1:0] w, wlast;

    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; acc[d] = 0; mword[d] = '0; accepts[d] = 0;
      prev_cs[d] = 1'b1; prev_sck[d] = 1'b0; prev_data[d] = 1'b0;
      low_len[d] = 0; high_len[d] = 0; rises[d] = 0; first_rise[d] = -1;
      last_rise[d] = -1; period[d] = 0; gap_rec[d] = 0; fr_rises[d] = 0;
      fr_low[d] = 0; fr_first[d] = 0; done_cnt[d] = 0; rdy_viol[d] = 0;
      cap_cnt[d] = 0; sreg[d] = '0; last_cap[d] = '0; prev_cap[d] = '0;
      freq_div[d] = '0; lfsr[d] = '0;
    end
    sys_rst_n  = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = '0;
    tx_valid_b = 1'b0; tx_data_b = '0;

    $display("[TB] reset");
    tick();
    tick();
    checkOutput("reset_state_a", 32'(outs(0)), 32'(IDLE_OUTS));
    checkOutput("reset_state_b", 32'(outs(1)), 32'(IDLE_OUTS));
    sys_rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] single frame");
    c0  = cap_cnt[0];
    dc0 = done_cnt[0];
    applyStimulus(0, 24'hA5F00F, 1'b0);
    waitIdle(0);
    checkOutput("t1_captures", 32'(cap_cnt[0] - c0), 32'd1);
    checkOutput("t1_word", 32'(last_cap[0]), 32'hA5F00F);
    checkOutput("t1_rises", 32'(fr_rises[0]), 32'd24);
    checkOutput("t1_cs_low", 32'(fr_low[0]), 32'd200);
    // Rise lands in the 9th cs-low cycle (index 8 counting the fall cycle as 0).
    checkOutput("t1_first_rise", 32'(fr_first[0]), 32'd8);
    checkOutput("t1_done_pulses", 32'(done_cnt[0] - dc0), 32'd1);

    $display("[TB] back-to-back with tx_valid held");
    c0 = cap_cnt[0];
    rdy_viol[0] = 0;
    applyStimulus(0, 24'h800001, 1'b1);
    applyStimulus(0, 24'h00CF08, 1'b0);
    waitIdle(0);
    checkOutput("t2_captures", 32'(cap_cnt[0] - c0), 32'd2);
    checkOutput("t2_first_word", 32'(prev_cap[0]), 32'h800001);
    checkOutput("t2_second_word", 32'(last_cap[0]), 32'h00CF08);
    checkOutput("t2_cs_high_gap", 32'(gap_rec[0]), 32'd9);
    checkOutput("t2_ready_in_frame", 32'(rdy_viol[0]), 32'd0);

    $display("[TB] tx_valid pulse while busy");
    c0 = cap_cnt[0];
    applyStimulus(0, 24'h0000FF, 1'b0);
    repeat (40) tick();
    tx_valid_a = 1'b1;
    tx_data_a  = 24'h123456;
    tick();
    tx_valid_a = 1'b0;
    waitIdle(0);
    repeat (20) tick();
    checkOutput("t3_captures", 32'(cap_cnt[0] - c0), 32'd1);
    checkOutput("t3_word", 32'(last_cap[0]), 32'h0000FF);
    checkOutput("t3_cs_idle", 32'(cs_a), 32'd1);

    $display("[TB] reset mid-frame");
    c0 = cap_cnt[0];
    applyStimulus(0, 24'h5A5A5A, 1'b0);
    for (int i = 0; i < 400 && !(rises[0] >= 10 && !prev_cs[0]); i++) tick();
    checkOutput("t4_reached_rise10", 32'(rises[0] >= 10), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t4_reset_outs", 32'(outs(0)), 32'(IDLE_OUTS));
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (2) tick();
    applyStimulus(0, 24'h7FFFFE, 1'b0);
    waitIdle(0);
    checkOutput("t4_captures", 32'(cap_cnt[0] - c0), 32'd1);
    checkOutput("t4_word", 32'(last_cap[0]), 32'h7FFFFE);

    $display("[TB] loopback register decode");
    applyStimulus(0, 24'h00CF08, 1'b0);
    waitIdle(0);
    checkOutput("t5_freq_div", 32'(freq_div[0]), 32'd53000);
    applyStimulus(0, 24'h80006F, 1'b0);
    waitIdle(0);
    checkOutput("t5_lfsr", 32'(lfsr[0]), 32'd111);

    $display("[TB] CLK_DIV=5 instance");
    c0 = cap_cnt[1];
    applyStimulus(1, 24'hFFFFFF, 1'b0);
    waitIdle(1);
    applyStimulus(1, 24'h000000, 1'b0);
    waitIdle(1);
    checkOutput("t6_captures", 32'(cap_cnt[1] - c0), 32'd2);
    checkOutput("t6_first_word", 32'(prev_cap[1]), 32'hFFFFFF);
    checkOutput("t6_second_word", 32'(last_cap[1]), 32'h000000);
    checkOutput("t6_sck_period", 32'(period[1]), 32'd10);
    checkOutput("t6_rises", 32'(fr_rises[1]), 32'd24);
    checkOutput("t6_cs_low", 32'(fr_low[1]), 32'd248);

    $display("[TB] randomized frames with busy-time noise");
    c0    = cap_cnt[0];
    wlast = '0;
    for (int f = 0; f < 6; f++) begin
      idle = $urandom_range(0, 5);
      repeat (idle) tick();
      w     = N'($urandom);
      wlast = w;
      applyStimulus(0, w, 1'b0);
      for (int i = 0; i < 400 && act[0] && (cyc - acc[0]) < low_of(0); i++) begin
        tx_valid_a = ($urandom_range(0, 3) == 0);
        tx_data_a  = N'($urandom);
        tick();
      end
      tx_valid_a = 1'b0;
      waitIdle(0);
    end
    checkOutput("t7_captures", 32'(cap_cnt[0] - c0), 32'd6);
    checkOutput("t7_last_word", 32'(last_cap[0]), 32'(wlast));

    repeat (5) tick();
    checkOutput("pending_a", 32'(exp_q0.size()), 32'd0);
    checkOutput("pending_b", 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
